// File: rtl/rx_fifo_scheduler_pkg.sv
// Shared types for the RX fabric scheduler: FSM state encoding and counter widths.
// Also imported by the TX-side scheduler; keep the encodings stable.
package rx_fifo_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_POP  = 2'd2,
    ST_GAP  = 2'd3
  } sched_state_t;

  localparam int FWD_CNT_W = 32;
  localparam int TO_CNT_W  = 16;

endpackage

// File: rtl/rx_fifo_scheduler_rr_picker.sv
// Combinational round-robin picker: first set request at or after last_grant+1, wrapping.
// Zero latency; no flow control, the caller decides when the result is used.
module rx_fifo_scheduler_rr_picker #(
  parameter int NUM_PORTS = 8,
  parameter int PORT_BITS = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_BITS-1:0] last_grant,
  output logic                 found,
  output logic [PORT_BITS-1:0] index
);

  logic [NUM_PORTS-1:0] rot;
  int                   start;
  int                   off;

  // Rotating the doubled vector puts the search start at bit 0, so a plain
  // lowest-set-bit encode yields the offset from the start position.
  always_comb begin
    start = (int'(last_grant) + 1) % NUM_PORTS;
    rot   = NUM_PORTS'({req, req} >> start);
    found = |rot;
    off   = 0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    index = PORT_BITS'((start + off) % NUM_PORTS);
  end

endmodule

// File: rtl/rx_fifo_scheduler.sv
// Round-robin owner of the shared forwarding path: fwd_en -> wait done/timeout -> pop -> holdoff.
// Grant one cycle after a ready request; crossbar_ready only gates new grants, never an active frame.
module rx_fifo_scheduler
  import rx_fifo_scheduler_pkg::*;
#(
  parameter int NUM_PORTS      = 8,
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int POP_HOLDOFF    = 2,
  parameter int PORT_BITS      = $clog2(NUM_PORTS)
) (
  input  logic                 fabric_clk,
  input  logic                 fabric_rst,
  input  logic [NUM_PORTS-1:0] port_frame_valid,
  input  logic [NUM_PORTS-1:0] port_frame_done,
  input  logic [NUM_PORTS-1:0] port_enable,
  input  logic                 crossbar_ready,
  output logic [NUM_PORTS-1:0] port_fwd_en,
  output logic [NUM_PORTS-1:0] port_pop,
  output logic                 grant_valid,
  output logic [PORT_BITS-1:0] grant_port,
  output logic                 timeout_pulse,
  output logic [FWD_CNT_W-1:0] frames_forwarded,
  output logic [TO_CNT_W-1:0]  timeout_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(POP_HOLDOFF + 1);

  sched_state_t         state_q, state_d;
  logic [PORT_BITS-1:0] last_grant_q, last_grant_d;
  logic [PORT_BITS-1:0] grant_port_d;
  logic                 grant_valid_d;
  logic [NUM_PORTS-1:0] fwd_en_d, pop_d;
  logic                 timeout_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 fwd_inc, to_inc;
  logic                 pick_found;
  logic [PORT_BITS-1:0] pick_idx;

  rx_fifo_scheduler_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_BITS (PORT_BITS)
  ) u_picker (
    .req        (port_frame_valid & port_enable),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .index      (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_port_d  = grant_port;
    grant_valid_d = grant_valid;
    fwd_en_d      = '0;
    pop_d         = '0;
    timeout_d     = 1'b0;
    tmr_d         = tmr_q;
    gap_d         = gap_q;
    fwd_inc       = 1'b0;
    to_inc        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (crossbar_ready && pick_found) begin
          state_d            = ST_WAIT;
          last_grant_d       = pick_idx;
          grant_port_d       = pick_idx;
          grant_valid_d      = 1'b1;
          fwd_en_d[pick_idx] = 1'b1;
          tmr_d              = '0;
        end
      end
      ST_WAIT: begin
        // Done has priority over the terminal count; port_enable is not consulted here.
        if (port_frame_done[grant_port]) begin
          state_d              = ST_POP;
          pop_d[grant_port]    = 1'b1;
          fwd_inc              = 1'b1;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d              = ST_POP;
          pop_d[grant_port]    = 1'b1;
          timeout_d            = 1'b1;
          fwd_inc              = 1'b1;
          to_inc               = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_POP: begin
        state_d       = ST_GAP;
        grant_valid_d = 1'b0;
        gap_d         = '0;
      end
      default: begin
        if (gap_q == GAP_W'(POP_HOLDOFF - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge fabric_clk) begin
    if (fabric_rst) begin
      state_q          <= ST_IDLE;
      last_grant_q     <= PORT_BITS'(NUM_PORTS - 1);
      grant_port       <= '0;
      grant_valid      <= 1'b0;
      port_fwd_en      <= '0;
      port_pop         <= '0;
      timeout_pulse    <= 1'b0;
      tmr_q            <= '0;
      gap_q            <= '0;
      frames_forwarded <= '0;
      timeout_count    <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_port    <= grant_port_d;
      grant_valid   <= grant_valid_d;
      port_fwd_en   <= fwd_en_d;
      port_pop      <= pop_d;
      timeout_pulse <= timeout_d;
      tmr_q         <= tmr_d;
      gap_q         <= gap_d;
      if (fwd_inc && (frames_forwarded != {FWD_CNT_W{1'b1}}))
        frames_forwarded <= frames_forwarded + 1'b1;
      if (to_inc && (timeout_count != {TO_CNT_W{1'b1}}))
        timeout_count <= timeout_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_fifo_scheduler.sv
// Directed bench for rx_fifo_scheduler (8 ports, 16-cycle timeout, holdoff 2).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rx_fifo_scheduler;

  logic        fabric_clk = 1'b0;
  logic        fabric_rst;
  logic [7:0]  port_frame_valid, port_frame_done, port_enable;
  logic        crossbar_ready;
  logic [7:0]  port_fwd_en, port_pop;
  logic        grant_valid;
  logic [2:0]  grant_port;
  logic        timeout_pulse;
  logic [31:0] frames_forwarded;
  logic [15:0] timeout_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  rx_fifo_scheduler #(
    .NUM_PORTS      (8),
    .TIMEOUT_CYCLES (16),
    .POP_HOLDOFF    (2)
  ) dut (
    .fabric_clk       (fabric_clk),
    .fabric_rst       (fabric_rst),
    .port_frame_valid (port_frame_valid),
    .port_frame_done  (port_frame_done),
    .port_enable      (port_enable),
    .crossbar_ready   (crossbar_ready),
    .port_fwd_en      (port_fwd_en),
    .port_pop         (port_pop),
    .grant_valid      (grant_valid),
    .grant_port       (grant_port),
    .timeout_pulse    (timeout_pulse),
    .frames_forwarded (frames_forwarded),
    .timeout_count    (timeout_count)
  );

  always #5 fabric_clk = ~fabric_clk;
  always @(posedge fabric_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge fabric_clk);
    #1;
  endtask

  task automatic do_reset();
    fabric_rst       = 1'b1;
    port_frame_valid = '0;
    port_frame_done  = '0;
    port_enable      = 8'hFF;
    crossbar_ready   = 1'b1;
    tick();
    tick();
    fabric_rst = 1'b0;
  endtask

  task automatic wait_grant(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (port_fwd_en != 8'h00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_done(input logic [7:0] m);
    port_frame_done = m;
    tick();
    port_frame_done = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({port_fwd_en, port_pop} !== 16'h0000) begin
      failures++; $display("FAIL reset_strobes got fwd=%h pop=%h want 00 00", port_fwd_en, port_pop);
    end
    checks++;
    if ({grant_valid, grant_port, timeout_pulse} !== 5'b0) begin
      failures++; $display("FAIL reset_grant got gv=%b gp=%0d to=%b want 0 0 0", grant_valid, grant_port, timeout_pulse);
    end
    checks++;
    if (frames_forwarded !== 32'd0 || timeout_count !== 16'd0) begin
      failures++; $display("FAIL reset_counters got ff=%0d tc=%0d want 0 0", frames_forwarded, timeout_count);
    end
  endtask

  task automatic test_single_port();
    bit stray;
    do_reset();
    port_frame_valid = 8'h08;
    tick();
    checks++;
    if (port_fwd_en !== 8'h08 || grant_valid !== 1'b1 || grant_port !== 3'd3) begin
      failures++; $display("FAIL single_grant got fwd=%h gv=%b gp=%0d want 08 1 3", port_fwd_en, grant_valid, grant_port);
    end
    port_frame_valid = 8'h00;
    tick();
    checks++;
    if (port_fwd_en !== 8'h00) begin
      failures++; $display("FAIL single_fwd_pulse got fwd=%h want 00", port_fwd_en);
    end
    pulse_done(8'h08);
    checks++;
    if (port_pop !== 8'h08 || frames_forwarded !== 32'd1 || grant_valid !== 1'b1) begin
      failures++; $display("FAIL single_pop got pop=%h ff=%0d gv=%b want 08 1 1", port_pop, frames_forwarded, grant_valid);
    end
    tick();
    checks++;
    if (port_pop !== 8'h00 || grant_valid !== 1'b0) begin
      failures++; $display("FAIL single_gap got pop=%h gv=%b want 00 0", port_pop, grant_valid);
    end
    stray = 1'b0;
    repeat (6) begin
      tick();
      if (port_pop != 8'h00 || port_fwd_en != 8'h00 || timeout_pulse) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      failures++; $display("FAIL single_quiet got stray=%b want 0", stray);
    end
  endtask

  task automatic test_fairness();
    int exp_port[6] = '{0, 2, 5, 0, 2, 5};
    int prev;
    bit ok;
    logic [7:0] m;
    do_reset();
    port_frame_valid = 8'h25;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_grant(30, ok);
      checks++;
      if (!ok) begin
        failures++; $display("FAIL fair_wait k=%0d got no grant within 30 cycles want grant", k);
        break;
      end
      m = 8'h01 << exp_port[k];
      checks++;
      if (port_fwd_en !== m || grant_port !== 3'(exp_port[k])) begin
        failures++; $display("FAIL fair_order k=%0d got fwd=%h gp=%0d want %h %0d", k, port_fwd_en, grant_port, m, exp_port[k]);
      end
      // done two cycles after fwd_en: 1 fwd + 2 wait + pop + 2 gap + idle = 7
      if (k > 0) begin
        checks++;
        if (cyc - prev !== 7) begin
          failures++; $display("FAIL fair_gap k=%0d got %0d want 7", k, cyc - prev);
        end
      end
      prev = cyc;
      tick();
      tick();
      pulse_done(m);
    end
    port_frame_valid = 8'h00;
    repeat (6) tick();
  endtask

  task automatic test_mask();
    bit ok;
    bit seen2;
    int n3;
    logic [7:0] m;
    do_reset();
    port_enable      = 8'hFB;
    port_frame_valid = 8'h0C;
    seen2 = 1'b0;
    n3    = 0;
    for (int k = 0; k < 3; k++) begin
      wait_grant(20, ok);
      if (!ok) break;
      m = port_fwd_en;
      if (m[2]) seen2 = 1'b1;
      if (m == 8'h08) n3++;
      pulse_done(m);
    end
    checks++;
    if (seen2 !== 1'b0 || n3 !== 3) begin
      failures++; $display("FAIL mask_port2 got seen2=%b grants3=%0d want 0 3", seen2, n3);
    end
    port_frame_valid = 8'h00;
    port_enable      = 8'hFF;
    repeat (6) tick();
  endtask

  task automatic test_ready();
    bit early;
    do_reset();
    crossbar_ready   = 1'b0;
    port_frame_valid = 8'h01;
    early = 1'b0;
    repeat (50) begin
      tick();
      if (port_fwd_en != 8'h00 || grant_valid) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++; $display("FAIL ready_hold got early_grant=%b want 0", early);
    end
    crossbar_ready = 1'b1;
    tick();
    checks++;
    if (port_fwd_en !== 8'h01) begin
      failures++; $display("FAIL ready_release got fwd=%h want 01", port_fwd_en);
    end
    port_frame_valid = 8'h00;
    pulse_done(8'h01);
    repeat (4) tick();
  endtask

  task automatic test_timeout();
    bit ok;
    bit early;
    // done withheld: pop + timeout 16 cycles after fwd_en
    do_reset();
    port_frame_valid = 8'h02;
    wait_grant(10, ok);
    port_frame_valid = 8'h00;
    early = 1'b0;
    repeat (15) begin
      tick();
      if (port_pop != 8'h00 || timeout_pulse) early = 1'b1;
    end
    checks++;
    if (!ok || early !== 1'b0) begin
      failures++; $display("FAIL to_early got granted=%b early_pop=%b want 1 0", ok, early);
    end
    tick();
    checks++;
    if (port_pop !== 8'h02 || timeout_pulse !== 1'b1) begin
      failures++; $display("FAIL to_fire got pop=%h to=%b want 02 1", port_pop, timeout_pulse);
    end
    checks++;
    if (timeout_count !== 16'd1 || frames_forwarded !== 32'd1) begin
      failures++; $display("FAIL to_counts got tc=%0d ff=%0d want 1 1", timeout_count, frames_forwarded);
    end
    tick();
    checks++;
    if (timeout_pulse !== 1'b0) begin
      failures++; $display("FAIL to_pulse_width got to=%b want 0", timeout_pulse);
    end
    repeat (4) tick();

    // done on the terminal-count cycle wins
    do_reset();
    port_frame_valid = 8'h02;
    wait_grant(10, ok);
    port_frame_valid = 8'h00;
    repeat (15) tick();
    pulse_done(8'h02);
    checks++;
    if (port_pop !== 8'h02 || timeout_pulse !== 1'b0 || timeout_count !== 16'd0) begin
      failures++; $display("FAIL to_done_wins got pop=%h to=%b tc=%0d want 02 0 0", port_pop, timeout_pulse, timeout_count);
    end
    repeat (4) tick();
  endtask

  task automatic test_stray_and_reset();
    bit ok;
    bit bad;
    do_reset();
    port_frame_valid = 8'h02;
    wait_grant(10, ok);
    checks++;
    if (!ok || grant_port !== 3'd1) begin
      failures++; $display("FAIL stray_grant got granted=%b gp=%0d want 1 1", ok, grant_port);
    end
    pulse_done(8'h10);
    bad = 1'b0;
    repeat (4) begin
      if (port_pop != 8'h00 || !grant_valid || grant_port != 3'd1) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL stray_ignored got disturbed=%b want 0", bad);
    end
    // port 5 would be next in round-robin order; reset must restart the search at 0
    port_frame_valid = 8'h22;
    fabric_rst = 1'b1;
    tick();
    checks++;
    if ({port_fwd_en, port_pop} !== 16'h0000 || {grant_valid, grant_port, timeout_pulse} !== 5'b0 ||
        frames_forwarded !== 32'd0) begin
      failures++; $display("FAIL midreset_outputs got fwd=%h pop=%h gv=%b gp=%0d to=%b ff=%0d want all 0",
                           port_fwd_en, port_pop, grant_valid, grant_port, timeout_pulse, frames_forwarded);
    end
    fabric_rst = 1'b0;
    wait_grant(10, ok);
    checks++;
    if (!ok || port_fwd_en !== 8'h02 || grant_port !== 3'd1) begin
      failures++; $display("FAIL midreset_restart got fwd=%h gp=%0d want 02 1", port_fwd_en, grant_port);
    end
    port_frame_valid = 8'h00;
    pulse_done(8'h02);
    repeat (4) tick();
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    force dut.frames_forwarded = 32'hFFFF_FFFE;
    force dut.timeout_count    = 16'hFFFF;
    #1;
    release dut.frames_forwarded;
    release dut.timeout_count;
    port_frame_valid = 8'h01;
    wait_grant(10, ok);
    port_frame_valid = 8'h00;
    pulse_done(8'h01);
    checks++;
    if (!ok || frames_forwarded !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL sat_reach got ff=%h want ffffffff", frames_forwarded);
    end
    repeat (4) tick();
    port_frame_valid = 8'h01;
    wait_grant(10, ok);
    port_frame_valid = 8'h00;
    repeat (16) tick();
    checks++;
    if (!ok || timeout_pulse !== 1'b1 || frames_forwarded !== 32'hFFFF_FFFF || timeout_count !== 16'hFFFF) begin
      failures++; $display("FAIL sat_hold got to=%b ff=%h tc=%h want 1 ffffffff ffff",
                           timeout_pulse, frames_forwarded, timeout_count);
    end
    repeat (4) tick();
  endtask

  initial begin
    fabric_rst       = 1'b1;
    port_frame_valid = '0;
    port_frame_done  = '0;
    port_enable      = 8'hFF;
    crossbar_ready   = 1'b0;
    test_reset();
    test_single_port();
    test_fairness();
    test_mask();
    test_ready();
    test_timeout();
    test_stray_and_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
